// File: rtl/axil_reg_slave.sv
// AXI-Lite register slave: word 0 is a read-only ID, remaining words are R/W
// with byte strobes. Independent write and read FSMs run concurrently.
module axil_reg_slave #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned AXIL_DATA_WIDTH = 32,
  parameter int unsigned AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
  parameter int unsigned NUM_REGS        = 16,
  parameter logic [AXIL_DATA_WIDTH-1:0] ID_VALUE = 32'hA5A5_0001
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      s_axil_awaddr,
  input  logic [2:0]                 s_axil_awprot,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]      s_axil_araddr,
  input  logic [2:0]                 s_axil_arprot,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready
);

  localparam int unsigned IDX_W       = $clog2(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                       awready_q, awready_d, wready_q, wready_d;
  logic                       bvalid_q, bvalid_d, arready_q, arready_d;
  logic                       rvalid_q, rvalid_d;
  logic [1:0]                 bresp_q, bresp_d, rresp_q, rresp_d;
  logic [AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]      awaddr_q;
  logic [AXIL_DATA_WIDTH-1:0] wdata_q;
  logic [AXIL_STRB_WIDTH-1:0] wstrb_q;
  logic [AXIL_DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                       aw_hs_c, w_hs_c, ar_hs_c, commit_c;
  logic [ADDR_WIDTH-1:0]      wr_addr_c;
  logic [AXIL_DATA_WIDTH-1:0] wr_data_c;
  logic [AXIL_STRB_WIDTH-1:0] wr_strb_c;
  logic [IDX_W-1:0]           wr_idx_c, rd_idx_c;
  logic                       wr_err_c, rd_oor_c;
  logic                       unused_c;

  assign unused_c = ^{s_axil_awprot, s_axil_arprot};

  assign aw_hs_c = s_axil_awvalid && awready_q;
  assign w_hs_c  = s_axil_wvalid && wready_q;
  assign ar_hs_c = s_axil_arvalid && arready_q;

  // A half arriving this cycle is used directly; the other comes from its latch.
  assign wr_addr_c = aw_hs_c ? s_axil_awaddr : awaddr_q;
  assign wr_data_c = w_hs_c ? s_axil_wdata : wdata_q;
  assign wr_strb_c = w_hs_c ? s_axil_wstrb : wstrb_q;
  assign wr_idx_c  = wr_addr_c[IDX_W+1:2];
  assign wr_err_c  = (|(wr_addr_c >> (IDX_W + 2))) || (wr_idx_c == '0);

  assign rd_idx_c  = s_axil_araddr[IDX_W+1:2];
  assign rd_oor_c  = |(s_axil_araddr >> (IDX_W + 2));

  always_comb begin
    w_state_d = w_state_q;
    commit_c  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) begin
          w_state_d = W_RESP;
          commit_c  = 1'b1;
        end else if (aw_hs_c) begin
          w_state_d = W_HAVE_ADDR;
        end else if (w_hs_c) begin
          w_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs_c) begin
          w_state_d = W_RESP;
          commit_c  = 1'b1;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs_c) begin
          w_state_d = W_RESP;
          commit_c  = 1'b1;
        end
      end
      W_RESP: begin
        if (s_axil_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = commit_c ? (wr_err_c ? RESP_SLVERR : RESP_OKAY) : bresp_q;
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          r_state_d = R_RESP;
          if (rd_oor_c) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else if (rd_idx_c == '0) begin
            rdata_d = ID_VALUE;
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = regs_q[rd_idx_c];
            rresp_d = RESP_OKAY;
          end
        end
      end
      R_RESP: begin
        if (s_axil_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      if (aw_hs_c) awaddr_q <= s_axil_awaddr;
      if (w_hs_c) begin
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
    end
  end

  // Register bank; commit happens on the edge that enters W_RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit_c && !wr_err_c) begin
      for (int unsigned b = 0; b < AXIL_STRB_WIDTH; b++) begin
        if (wr_strb_c[b]) regs_q[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
      end
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: directed and randomized AXI-Lite traffic checked
// against a word-array model of the register map.
module tb_axil_reg_slave;

  localparam int unsigned NREGS = 16;
  localparam logic [31:0] ID    = 32'hA5A5_0001;

  logic        clk, rst;
  logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
  logic [2:0]  s_axil_awprot, s_axil_arprot;
  logic [3:0]  s_axil_wstrb;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready;

  axil_reg_slave #(
    .ADDR_WIDTH(32), .AXIL_DATA_WIDTH(32), .AXIL_STRB_WIDTH(4),
    .NUM_REGS(NREGS), .ID_VALUE(ID)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [NREGS];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: word-granular map, out-of-range above NREGS words.
  function automatic bit is_oor(input logic [31:0] a);
    return (a >> 2) >= NREGS;
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    return int'((a >> 2) % NREGS);
  endfunction

  function automatic logic [1:0] exp_wresp(input logic [31:0] a);
    return (is_oor(a) || word_of(a) == 0) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [31:0] a);
    return is_oor(a) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (is_oor(a)) return 32'h0;
    if (word_of(a) == 0) return ID;
    return mem[word_of(a)];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (exp_wresp(a) == 2'b00)
      for (int b = 0; b < 4; b++)
        if (s[b]) mem[word_of(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  // Issues AW and W with independent start delays; ends with bvalid pending.
  task automatic write_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    bit aw_done, w_done, aw_hs, w_hs;
    aw_done = 1'b0;
    w_done  = 1'b0;
    for (int cyc = 0; cyc < 50 && !(aw_done && w_done); cyc++) begin
      s_axil_awaddr  = a;
      s_axil_awprot  = 3'($urandom);
      s_axil_wdata   = d;
      s_axil_wstrb   = s;
      s_axil_awvalid = !aw_done && cyc >= aw_dly;
      s_axil_wvalid  = !w_done && cyc >= w_dly;
      @(negedge clk);
      chk("awready_open", 32'(s_axil_awready), 32'(!aw_done));
      chk("wready_open", 32'(s_axil_wready), 32'(!w_done));
      aw_hs = s_axil_awvalid && s_axil_awready;
      w_hs  = s_axil_wvalid && s_axil_wready;
      @(posedge clk); #1;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    chk("write_handshakes", 32'({aw_done, w_done}), 32'h3);
    model_write(a, d, s);
    chk("bvalid_after_hs", 32'(s_axil_bvalid), 32'h1);
    chk("bresp", 32'(s_axil_bresp), 32'(exp_wresp(a)));
  endtask

  task automatic write_resp(input int stall, input logic [1:0] er);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("bvalid_stall", 32'(s_axil_bvalid), 32'h1);
      chk("bresp_stall", 32'(s_axil_bresp), 32'(er));
      chk("awready_stall", 32'(s_axil_awready), 32'h0);
      chk("wready_stall", 32'(s_axil_wready), 32'h0);
      @(posedge clk); #1;
    end
    s_axil_bready = 1'b1;
    @(negedge clk);
    chk("bvalid_hs", 32'(s_axil_bvalid), 32'h1);
    @(posedge clk); #1;
    s_axil_bready = 1'b0;
    chk("bvalid_drop", 32'(s_axil_bvalid), 32'h0);
    chk("awready_back", 32'(s_axil_awready), 32'h1);
    chk("wready_back", 32'(s_axil_wready), 32'h1);
  endtask

  task automatic write_full(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int stall);
    write_req(a, d, s, aw_dly, w_dly);
    write_resp(stall, exp_wresp(a));
  endtask

  task automatic read_chk(input logic [31:0] a, input int stall);
    logic [31:0] ed;
    logic [1:0]  er;
    bit done, hs;
    done = 1'b0;
    ed   = 32'h0;
    er   = 2'b00;
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      s_axil_araddr  = a;
      s_axil_arprot  = 3'($urandom);
      s_axil_arvalid = 1'b1;
      @(negedge clk);
      chk("arready_idle", 32'(s_axil_arready), 32'h1);
      hs = s_axil_arvalid && s_axil_arready;
      if (hs) begin
        ed = exp_rdata(a);
        er = exp_rresp(a);
      end
      @(posedge clk); #1;
      done = hs;
    end
    s_axil_arvalid = 1'b0;
    chk("ar_handshake", 32'(done), 32'h1);
    chk("rvalid_after_hs", 32'(s_axil_rvalid), 32'h1);
    chk("rdata", s_axil_rdata, ed);
    chk("rresp", 32'(s_axil_rresp), 32'(er));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("rvalid_stall", 32'(s_axil_rvalid), 32'h1);
      chk("rdata_stall", s_axil_rdata, ed);
      chk("rresp_stall", 32'(s_axil_rresp), 32'(er));
      chk("arready_stall", 32'(s_axil_arready), 32'h0);
      @(posedge clk); #1;
    end
    s_axil_rready = 1'b1;
    @(negedge clk);
    chk("rvalid_hs", 32'(s_axil_rvalid), 32'h1);
    @(posedge clk); #1;
    s_axil_rready = 1'b0;
    chk("rvalid_drop", 32'(s_axil_rvalid), 32'h0);
    chk("arready_back", 32'(s_axil_arready), 32'h1);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    for (int i = 0; i < NREGS; i++) mem[i] = 32'h0;
    rst = 1'b0;
    s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
    s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
    #12;
    chk("rst_awready", 32'(s_axil_awready), 32'h0);
    chk("rst_wready", 32'(s_axil_wready), 32'h0);
    chk("rst_arready", 32'(s_axil_arready), 32'h0);
    chk("rst_bvalid", 32'(s_axil_bvalid), 32'h0);
    chk("rst_rvalid", 32'(s_axil_rvalid), 32'h0);
    chk("rst_rdata", s_axil_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_arready", 32'(s_axil_arready), 32'h1);
    chk("post_rst_awready", 32'(s_axil_awready), 32'h1);
    chk("post_rst_wready", 32'(s_axil_wready), 32'h1);

    // ID read, same-cycle write, W leading AW with partial strobes
    read_chk(32'h0, 0);
    write_full(32'h8, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    read_chk(32'h8, 0);
    chk("dir_word8", exp_rdata(32'h8), 32'hDEAD_BEEF);
    write_full(32'h4, 32'h1122_3344, 4'h5, 3, 0, 0);
    read_chk(32'h4, 0);
    chk("dir_word4", exp_rdata(32'h4), 32'h0022_0044);
    write_full(32'h0C, 32'hCAFE_F00D, 4'hF, 0, 2, 1);
    read_chk(32'h0C, 1);

    // Error decode: ID write, out-of-range write and read
    write_full(32'h0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    read_chk(32'h0, 0);
    write_full(32'h40, 32'h1234_5678, 4'hF, 1, 0, 0);
    read_chk(32'h40, 0);
    read_chk(32'h8000_0010, 0);

    // Empty strobe, unaligned low bits
    write_full(32'h8, 32'h0000_0000, 4'h0, 0, 0, 0);
    read_chk(32'h8, 0);
    write_full(32'h13, 32'hA1B2_C3D4, 4'hA, 0, 0, 0);
    read_chk(32'h10, 0);

    // Stalled write response with a read proceeding alongside
    write_req(32'h14, 32'h5566_7788, 4'hF, 0, 0);
    read_chk(32'h14, 5);
    write_resp(5, 2'b00);

    // Randomized mix
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) a = 32'h40 + 32'($urandom_range(0, 255));
      else a = 32'($urandom_range(0, NREGS * 4 - 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        write_full(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        read_chk(a, $urandom_range(0, 3));
    end

    // Asynchronous reset while a write response is pending
    write_req(32'h8, 32'h0BAD_0BAD, 4'hF, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_bvalid", 32'(s_axil_bvalid), 32'h0);
    chk("async_rst_awready", 32'(s_axil_awready), 32'h0);
    chk("async_rst_arready", 32'(s_axil_arready), 32'h0);
    for (int i = 0; i < NREGS; i++) mem[i] = 32'h0;
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("rerst_awready", 32'(s_axil_awready), 32'h1);
    chk("rerst_arready", 32'(s_axil_arready), 32'h1);
    chk("rerst_bvalid", 32'(s_axil_bvalid), 32'h0);
    read_chk(32'h8, 0);
    read_chk(32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
AXI-Lite responder (slave) terminating the master-side AXI-Lite channel set with a bank of NUM_REGS 32-bit control/status registers. Write and read paths are independent FSMs that run concurrently. It is the endpoint used by bridge and VIP benches as the memory-mapped target. Word 0 is a read-only ID register; all other words are read/write with byte strobes.

Parameters:
ADDR_WIDTH, 32, byte address width
AXIL_DATA_WIDTH, 32, data width; only 32 supported
AXIL_STRB_WIDTH, AXIL_DATA_WIDTH/8, strobe width
NUM_REGS, 16, register count; power of two, 2..256
ID_VALUE, 32'hA5A5_0001, constant returned by word 0

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
s_axil_awaddr  input  ADDR_WIDTH  write address
s_axil_awprot  input  3  ignored
s_axil_awvalid  input  1  write address valid
s_axil_awready  output  1  write address ready
s_axil_wdata  input  AXIL_DATA_WIDTH  write data
s_axil_wstrb  input  AXIL_STRB_WIDTH  byte enables
s_axil_wvalid  input  1  write data valid
s_axil_wready  output  1  write data ready
s_axil_bresp  output  2  write response
s_axil_bvalid  output  1  write response valid
s_axil_bready  input  1  write response ready
s_axil_araddr  input  ADDR_WIDTH  read address
s_axil_arprot  input  3  ignored
s_axil_arvalid  input  1  read address valid
s_axil_arready  output  1  read address ready
s_axil_rdata  output  AXIL_DATA_WIDTH  read data
s_axil_rresp  output  2  read response
s_axil_rvalid  output  1  read data valid
s_axil_rready  input  1  read data ready

Behaviour:
- Reset (rst=0, async): all outputs 0; registers 1..NUM_REGS-1 cleared to 0; both FSMs to IDLE; in-flight transactions abandoned, no response issued. First edge after release drives awready=wready=arready=1.
- Decode: index = addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored. Out of range if any addr bit above log2(NUM_REGS)+1 is set -> SLVERR (2'b10), no state change, rdata=0. Otherwise OKAY (2'b00).
- Write to word 0 -> SLVERR, ID unchanged.
- Write FSM: W_IDLE (awready=1, wready=1), W_HAVE_ADDR (awready=0, wready=1), W_HAVE_DATA (awready=1, wready=0), W_RESP (awready=wready=0, bvalid=1).
- AW and W accepted in any order or in the same cycle; each channel's payload is latched on its own handshake. W_IDLE goes to W_HAVE_ADDR or W_HAVE_DATA on a single handshake, or directly to W_RESP on both.
- When both halves are held, the commit occurs on the same edge that enters W_RESP: for each byte b, reg[b] <= wdata[b] if wstrb[b]. bvalid rises the cycle after the last handshake.
- W_RESP holds bvalid/bresp stable until bready=1. Then -> W_IDLE with both readies 1 the next cycle, giving one write per 2 cycles minimum.
- Read FSM: R_IDLE (arready=1) -> R_RESP on AR handshake. rdata/rresp are registered on that edge; rvalid=1 the next cycle. Data is held stable until rready=1, then -> R_IDLE. arready=0 in R_RESP.
- Simultaneous read and write commit to the same word on the same edge: read returns the pre-write value.
- wstrb=0 -> OKAY, no bytes change.
- Master deasserting valid before ready is protocol violation; behaviour undefined. The bench asserts it never happens.

Test Plan:
- Reset then read addr 0x0 -> arready=1 first cycle post-reset, rdata=0xA5A5_0001, rresp=OKAY, rvalid 1 cycle after AR handshake.
- Same-cycle AW 0x8 / W 0xDEAD_BEEF strb 0xF, bready=1 -> bvalid next cycle, OKAY; read 0x8 returns 0xDEAD_BEEF.
- W leads AW by 3 cycles to 0x4, strb 0x5, data 0x1122_3344 over prior 0 -> awready held 1, wready 0 after W; read 0x4 = 0x0022_0044.
- Write 0x0 and write/read 0x40 (NUM_REGS=16) -> SLVERR each, ID intact, rdata=0.
- bready and rready low 5 cycles -> bvalid/rvalid, bresp/rdata stable; no new AW/W/AR accepted; reads proceed during a stalled write.
- rst=0 asserted while bvalid=1 -> bvalid falls immediately, reg 8 reads 0 after release.
